// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
//   Converts one 256-bit line fill / writeback request into a 4-beat 64-bit
//   burst on the downstream side. Beats are counted on burst_resp, so gaps
//   between beats are tolerated.
//
// Ports
//   clk, rst_n              : clock (rising edge), async active-low reset
//   line_read, line_write   : upstream requests, sampled only in IDLE
//   line_address            : upstream address (line aligned on latch)
//   line_wdata              : line to write back
//   line_rdata              : last completed fill line
//   line_resp               : one-cycle completion pulse
//   burst_address           : latched, line-aligned address
//   burst_read, burst_write : held high for the whole READ / WRITE state
//   burst_wdata             : outgoing beat (0 outside WRITE)
//   burst_rdata, burst_resp : incoming beat and beat-valid
//   err                     : timeout pulse (constant 0 unless enabled)
//
// Build option
//   LBA_TIMEOUT_EN : when defined, a stalled burst aborts after TIMEOUT
//                    cycles without a beat and err pulses for one cycle.
//
// States
//   IDLE  | waiting for a line request
//   READ  | collecting 4 beats from memory
//   WRITE | sending 4 beats to memory
//   DONE  | line_resp pulse, then back to IDLE

module line_burst_adaptor #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [31:0]  line_address,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic [31:0]  burst_address,
  output logic         burst_read,
  output logic         burst_write,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     cnt;
  logic [31:0]    addr_q;
  logic [255:0]   wdata_q;
  logic [191:0]   fill_q;
  logic           busy;
  logic           beat;
  logic           timeout_hit;

  assign busy = (state == READ) || (state == WRITE);
  assign beat = busy && burst_resp;

`ifdef LBA_TIMEOUT_EN
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TCNT_W-1:0] tcnt;
  logic              err_q;

  // Idle holds the counter at 0, which also clears it on entry to a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (!busy || beat) tcnt <= '0;
      else               tcnt <= tcnt + 1'b1;
    end
  end

  // The TIMEOUT-th consecutive beatless cycle is the last one spent in the burst.
  assign timeout_hit = busy && !beat && (tcnt == TCNT_W'(TIMEOUT - 1));
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;

  // TIMEOUT only matters to the timeout build; referenced here so the
  // parameter stays part of the interface in every build.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (line_write)     state_nxt = WRITE;
        else if (line_read) state_nxt = READ;
      end
      READ, WRITE: begin
        if (timeout_hit)               state_nxt = IDLE;
        else if (beat && cnt == 2'd3)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beats 0..2 land in a staging buffer; line_rdata is replaced only when
  // the fourth beat arrives, so it never shows a partial or aborted fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      line_rdata <= '0;
    end else begin
      if (state == IDLE && state_nxt != IDLE) begin
        addr_q  <= line_address & 32'hFFFF_FFE0;
        wdata_q <= line_wdata;
        cnt     <= 2'd0;
      end else if (beat) begin
        cnt <= cnt + 2'd1;
        if (state == READ) begin
          unique case (cnt)
            2'd0:    fill_q[63:0]    <= burst_rdata;
            2'd1:    fill_q[127:64]  <= burst_rdata;
            2'd2:    fill_q[191:128] <= burst_rdata;
            default: line_rdata      <= {burst_rdata, fill_q};
          endcase
        end
      end
    end
  end

  assign burst_address = addr_q;
  assign burst_read    = (state == READ);
  assign burst_write   = (state == WRITE);
  assign line_resp     = (state == DONE);
  assign burst_wdata   = (state == WRITE) ? wdata_q[{cnt, 6'd0} +: 64] : 64'd0;

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst_n;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  logic         err;

  line_burst_adaptor #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0]  R1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0]  R2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0]  R3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0]  R4 = 64'h4444_4444_4444_4444;
  localparam logic [255:0] LINE_R = {R4, R3, R2, R1};
  localparam logic [63:0]  W0 = 64'hDEAD_BEEF_0000_0000;
  localparam logic [63:0]  W1 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0]  W2 = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0]  W3 = 64'hDEAD_BEEF_0000_0003;
  localparam logic [255:0] LINE_W = {W3, W2, W1, W0};
  localparam logic [63:0]  JUNK = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic         rd, wr;
    logic [31:0]  addr;
    logic [255:0] wd;
    logic         resp;
    logic [63:0]  rdata;
    logic         e_bread, e_bwrite, e_lresp;
    logic         c_baddr;
    logic [31:0]  e_baddr;
    logic [63:0]  e_bwdata;
    logic         c_lrdata;
    logic [255:0] e_lrdata;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [255:0] wd,
                              logic resp, logic [63:0] rdata,
                              logic ebr, logic ebw, logic elr,
                              logic cba, logic [31:0] eba, logic [63:0] ebwd,
                              logic clr, logic [255:0] elrd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.resp = resp; v.rdata = rdata;
    v.e_bread = ebr; v.e_bwrite = ebw; v.e_lresp = elr;
    v.c_baddr = cba; v.e_baddr = eba; v.e_bwdata = ebwd;
    v.c_lrdata = clr; v.e_lrdata = elrd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1-2 ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wd, input logic resp, input logic [63:0] rdata);
    line_read = rd; line_write = wr; line_address = addr; line_wdata = wd;
    burst_resp = resp; burst_rdata = rdata;
  endtask

  // Plain 4-beat read starting from IDLE; checks address, completion and data.
  task automatic read_line(input string nm, input logic [31:0] addr, input logic [31:0] eaddr);
    logic [63:0] beats[4];
    beats[0] = R1; beats[1] = R2; beats[2] = R3; beats[3] = R4;
    drive(1'b1, 1'b0, addr, '0, 1'b0, '0);
    step();
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, beats[b]);
      #1;
      chk({nm, " bread"}, 256'(burst_read), 256'(1'b1));
      if (b == 0) chk({nm, " baddr"}, 256'(burst_address), 256'(eaddr));
      step();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    chk({nm, " lresp"}, 256'(line_resp), 256'(1'b1));
    step();
    chk({nm, " lrdata"}, line_rdata, LINE_R);
  endtask

  initial begin
    int n;
    logic seen_resp;
    logic [63:0]  gb[4];
    logic         gpat[7];

    // Read then write; request cycle is cycle 0, line_resp appears in
    // cycle 5 (the sixth cycle of the transaction) with back-to-back beats.
    tbl[0]  = mk(1,0,32'h0000_1234,'0,    0,'0,  0,0,0, 0,'0,           '0, 1,'0);
    tbl[1]  = mk(0,0,'0,'0,               1,R1,  1,0,0, 1,32'h0000_1220,'0, 1,'0);
    tbl[2]  = mk(0,0,'0,'0,               1,R2,  1,0,0, 1,32'h0000_1220,'0, 1,'0);
    tbl[3]  = mk(0,0,'0,'0,               1,R3,  1,0,0, 1,32'h0000_1220,'0, 1,'0);
    tbl[4]  = mk(0,0,'0,'0,               1,R4,  1,0,0, 1,32'h0000_1220,'0, 1,'0);
    tbl[5]  = mk(0,0,'0,'0,               0,'0,  0,0,1, 1,32'h0000_1220,'0, 1,LINE_R);
    tbl[6]  = mk(0,0,'0,'0,               0,'0,  0,0,0, 0,'0,           '0, 1,LINE_R);
    tbl[7]  = mk(0,1,32'h0000_ABCD,LINE_W,0,'0,  0,0,0, 0,'0,           '0, 1,LINE_R);
    tbl[8]  = mk(0,0,'0,'0,               1,JUNK,0,1,0, 1,32'h0000_ABC0,W0, 1,LINE_R);
    tbl[9]  = mk(0,0,'0,'0,               1,JUNK,0,1,0, 1,32'h0000_ABC0,W1, 1,LINE_R);
    tbl[10] = mk(0,0,'0,'0,               1,JUNK,0,1,0, 1,32'h0000_ABC0,W2, 1,LINE_R);
    tbl[11] = mk(0,0,'0,'0,               1,JUNK,0,1,0, 1,32'h0000_ABC0,W3, 1,LINE_R);
    tbl[12] = mk(0,0,'0,'0,               0,'0,  0,0,1, 0,'0,           '0, 1,LINE_R);
    tbl[13] = mk(0,0,'0,'0,               1,JUNK,0,0,0, 0,'0,           '0, 1,LINE_R);
    tbl[14] = mk(0,0,'0,'0,               0,'0,  0,0,0, 0,'0,           '0, 1,LINE_R);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #12;
    chk("reset state bread",  256'(burst_read),    256'(1'b0));
    chk("reset state bwrite", 256'(burst_write),   256'(1'b0));
    chk("reset state lresp",  256'(line_resp),     256'(1'b0));
    chk("reset state baddr",  256'(burst_address), 256'(32'd0));
    chk("reset state lrdata", line_rdata,          256'd0);
    chk("reset state err",    256'(err),           256'(1'b0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].resp, tbl[i].rdata);
      #1;
      chk($sformatf("vec%0d bread", i),  256'(burst_read),  256'(tbl[i].e_bread));
      chk($sformatf("vec%0d bwrite", i), 256'(burst_write), 256'(tbl[i].e_bwrite));
      chk($sformatf("vec%0d lresp", i),  256'(line_resp),   256'(tbl[i].e_lresp));
      chk($sformatf("vec%0d bwdata", i), 256'(burst_wdata), 256'(tbl[i].e_bwdata));
      chk($sformatf("vec%0d err", i),    256'(err),         256'(1'b0));
      if (tbl[i].c_baddr)
        chk($sformatf("vec%0d baddr", i), 256'(burst_address), 256'(tbl[i].e_baddr));
      if (tbl[i].c_lrdata)
        chk($sformatf("vec%0d lrdata", i), line_rdata, tbl[i].e_lrdata);
      step();
    end

    // Gapped beats: only the cycles with burst_resp=1 carry data.
    gb[0] = 64'hA000_0000_0000_0000; gb[1] = 64'hA000_0000_0000_0001;
    gb[2] = 64'hA000_0000_0000_0002; gb[3] = 64'hA000_0000_0000_0003;
    gpat[0] = 1; gpat[1] = 0; gpat[2] = 0; gpat[3] = 1; gpat[4] = 1; gpat[5] = 0; gpat[6] = 1;
    drive(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, '0);
    step();
    n = 0;
    for (int p = 0; p < 7; p++) begin
      if (gpat[p]) begin
        drive(1'b0, 1'b0, '0, '0, 1'b1, gb[n]);
        n++;
      end else begin
        drive(1'b0, 1'b0, '0, '0, 1'b0, JUNK);
      end
      #1;
      chk($sformatf("gap cyc%0d bread", p), 256'(burst_read), 256'(1'b1));
      chk($sformatf("gap cyc%0d lresp", p), 256'(line_resp),  256'(1'b0));
      step();
    end
    // burst_resp held high through DONE and into IDLE must be ignored.
    drive(1'b0, 1'b0, '0, '0, 1'b1, JUNK);
    #1;
    chk("gap done lresp", 256'(line_resp), 256'(1'b1));
    chk("gap done bread", 256'(burst_read), 256'(1'b0));
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("gap idle lresp",  256'(line_resp),  256'(1'b0));
    chk("gap idle bread",  256'(burst_read), 256'(1'b0));
    chk("gap lrdata",      line_rdata, {gb[3], gb[2], gb[1], gb[0]});
    step();

    // Simultaneous read and write: write wins.
    drive(1'b1, 1'b1, 32'h0000_0100, LINE_W, 1'b0, '0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("both bwrite", 256'(burst_write), 256'(1'b1));
    chk("both bread",  256'(burst_read),  256'(1'b0));
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, JUNK);
      step();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("both lresp",  256'(line_resp), 256'(1'b1));
    chk("both lrdata", line_rdata, {gb[3], gb[2], gb[1], gb[0]});
    step();

    // Reset mid-read after two beats.
    drive(1'b1, 1'b0, 32'h0000_2000, '0, 1'b0, '0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1, R1);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1, R2);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst bread",  256'(burst_read),    256'(1'b0));
    chk("midrst bwrite", 256'(burst_write),   256'(1'b0));
    chk("midrst lresp",  256'(line_resp),     256'(1'b0));
    chk("midrst baddr",  256'(burst_address), 256'(32'd0));
    chk("midrst lrdata", line_rdata,          256'd0);
    #1;
    rst_n = 1'b1;
    step();
    chk("postrst lresp", 256'(line_resp), 256'(1'b0));
    read_line("postrst", 32'h0000_301F, 32'h0000_3000);

    // Stalled read.
    drive(1'b1, 1'b0, 32'h0000_4000, '0, 1'b0, '0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
`ifdef LBA_TIMEOUT_EN
    n = 0;
    seen_resp = 1'b0;
    while (burst_read && n < 50) begin
      if (err || line_resp) seen_resp = 1'b1;
      n++;
      step();
    end
    chk("tmo cycles in READ", 256'(n),         256'(8));
    chk("tmo early err/resp", 256'(seen_resp), 256'(1'b0));
    chk("tmo err pulse",      256'(err),       256'(1'b1));
    chk("tmo lresp",          256'(line_resp), 256'(1'b0));
    chk("tmo lrdata",         line_rdata,      LINE_R);
    step();
    chk("tmo err cleared",    256'(err),        256'(1'b0));
    chk("tmo idle bread",     256'(burst_read), 256'(1'b0));
    chk("tmo idle lresp",     256'(line_resp),  256'(1'b0));
    read_line("after tmo", 32'h0000_5000, 32'h0000_5000);
`else
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("stall cyc%0d bread", c), 256'(burst_read), 256'(1'b1));
      chk($sformatf("stall cyc%0d err", c),   256'(err),        256'(1'b0));
      step();
    end
    for (int b = 0; b < 4; b++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, (b == 0) ? R1 : (b == 1) ? R2 : (b == 2) ? R3 : R4);
      step();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    chk("stall lresp", 256'(line_resp), 256'(1'b1));
    step();
    chk("stall lrdata", line_rdata, LINE_R);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
